rptr_empty: RTL and testbench

RPTR_EMPTY -- requirements
Module: rptr_empty

---
 rtl/rptr_empty.sv | 91 +++++++++
 tb/tb_rptr_empty.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rptr_empty.sv
// Read-side pointer and empty / almost-empty flag logic for an async FIFO.
// Optional registered occupancy output rlevel is enabled by defining RPTR_LEVEL_EN.
module rptr_empty #(
  parameter int unsigned PTR_WIDTH     = 8,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic                   rinc,
  input  logic [PTR_WIDTH-1:0]   rq2_wptr,
  output logic [PTR_WIDTH-2:0]   raddr,
  output logic [PTR_WIDTH-1:0]   rptr,
  output logic                   rempty,
  output logic                   raempty,
`ifdef RPTR_LEVEL_EN
  output logic                   runderflow,
  output logic [PTR_WIDTH-1:0]   rlevel
`else
  output logic                   runderflow
`endif
);

  localparam int unsigned ADDR_WIDTH = PTR_WIDTH - 1;

  logic [PTR_WIDTH-1:0] r_bin;
  logic [PTR_WIDTH-1:0] r_gray;
  logic                 r_empty;
  logic                 r_aempty;
  logic                 r_underflow;

  logic                 w_rd_ok;
  logic [PTR_WIDTH-1:0] w_bin_next;
  logic [PTR_WIDTH-1:0] w_gray_next;
  logic [PTR_WIDTH-1:0] w_wbin;
  logic [PTR_WIDTH-1:0] w_level_next;
  logic                 w_empty_next;
  logic                 w_aempty_next;

  assign w_rd_ok     = rinc & ~r_empty;
  assign w_bin_next  = r_bin + {{(PTR_WIDTH-1){1'b0}}, w_rd_ok};
  assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    w_wbin = '0;
    for (int i = 0; i < int'(PTR_WIDTH); i++) begin
      w_wbin[i] = ^(rq2_wptr >> i);
    end
  end

  assign w_level_next  = w_wbin - w_bin_next;
  assign w_empty_next  = (w_gray_next == rq2_wptr);
  assign w_aempty_next = (32'(w_level_next) <= AEMPTY_THRESH) | w_empty_next;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_bin       <= '0;
      r_gray      <= '0;
      r_empty     <= 1'b1;
      r_aempty    <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_bin       <= w_bin_next;
      r_gray      <= w_gray_next;
      r_empty     <= w_empty_next;
      r_aempty    <= w_aempty_next;
      r_underflow <= rinc & r_empty;
    end
  end

`ifdef RPTR_LEVEL_EN
  logic [PTR_WIDTH-1:0] r_level;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_level <= '0;
    end else begin
      r_level <= w_level_next;
    end
  end

  assign rlevel = r_level;
`endif

  assign raddr      = r_bin[ADDR_WIDTH-1:0];
  assign rptr       = r_gray;
  assign rempty     = r_empty;
  assign raempty    = r_aempty;
  assign runderflow = r_underflow;

endmodule

// File: tb/tb_rptr_empty.sv
// Self-checking bench for rptr_empty: directed vector table, corner sequences,
// and randomized traffic against a counter-based occupancy model.
module tb_rptr_empty;

  localparam int unsigned PW = 5;
  localparam int unsigned TH = 2;
  localparam int          MOD = 32;

  logic          rclk;
  logic          rrst_n;
  logic          rinc;
  logic [PW-1:0] rq2_wptr;
  logic [PW-2:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic          raempty;
  logic          runderflow;
`ifdef RPTR_LEVEL_EN
  logic [PW-1:0] rlevel;
`endif

  rptr_empty #(
    .PTR_WIDTH    (PW),
    .AEMPTY_THRESH(TH)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rinc      (rinc),
    .rq2_wptr  (rq2_wptr),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .raempty   (raempty),
`ifdef RPTR_LEVEL_EN
    .runderflow(runderflow),
    .rlevel    (rlevel)
`else
    .runderflow(runderflow)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: plain read/write counts; everything else derived arithmetically.
  int m_rd = 0;
  int m_wr = 0;
  bit m_empty = 1'b1;
  int e_lvl;
  bit e_uf, e_aempty, e_acc;
  logic [PW-1:0] prev_rptr;

  function automatic logic [PW-1:0] gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd = 0;
    m_wr = 0;
    m_empty = 1'b1;
  endtask

  task automatic model_step(input bit ri);
    e_acc    = ri && !m_empty;
    e_uf     = ri && m_empty;
    m_rd     = (m_rd + (e_acc ? 1 : 0)) % MOD;
    e_lvl    = (m_wr - m_rd + MOD) % MOD;
    m_empty  = (e_lvl == 0);
    e_aempty = (e_lvl <= int'(TH));
  endtask

  task automatic cycle(input bit ri, input int w);
    rinc      = ri;
    m_wr      = w % MOD;
    rq2_wptr  = gray(m_wr);
    prev_rptr = rptr;
    @(posedge rclk);
    #1;
    model_step(ri);
    chk("raddr", int'(raddr), m_rd % 16);
    chk("rptr", int'(rptr), int'(gray(m_rd)));
    chk("rempty", int'(rempty), int'(m_empty));
    chk("raempty", int'(raempty), int'(e_aempty));
    chk("runderflow", int'(runderflow), int'(e_uf));
    if (e_acc) chk("rptr_onebit", $countones(prev_rptr ^ rptr), 1);
    else       chk("rptr_hold", int'(rptr), int'(prev_rptr));
`ifdef RPTR_LEVEL_EN
    chk("rlevel", int'(rlevel), e_lvl);
`endif
  endtask

  typedef struct {
    bit ri;
    int w;
    int e_raddr;
    int e_rptr;
    bit e_empty;
    bit e_aempty;
    bit e_uf;
    int e_level;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 3, 0, 5'b00000, 0, 0, 0, 3};  // write pointer jumps to 3
    vecs[1] = '{1, 3, 1, 5'b00001, 0, 1, 0, 2};
    vecs[2] = '{1, 3, 2, 5'b00011, 0, 1, 0, 1};
    vecs[3] = '{1, 3, 3, 5'b00010, 1, 1, 0, 0};  // final read -> empty
    vecs[4] = '{1, 3, 3, 5'b00010, 1, 1, 1, 0};  // rejected read
    vecs[5] = '{0, 3, 3, 5'b00010, 1, 1, 0, 0};
    vecs[6] = '{0, 5, 3, 5'b00010, 0, 1, 0, 2};
    vecs[7] = '{1, 6, 4, 5'b00110, 0, 1, 0, 2};  // read + write together
    vecs[8] = '{1, 6, 5, 5'b00111, 0, 1, 0, 1};

    rinc = 1'b0;
    rq2_wptr = '0;
    rrst_n = 1'b1;
    #1 rrst_n = 1'b0;
    #2;
    chk("rst_rempty", int'(rempty), 1);
    chk("rst_raempty", int'(raempty), 1);
    chk("rst_rptr", int'(rptr), 0);
    chk("rst_raddr", int'(raddr), 0);
    chk("rst_runderflow", int'(runderflow), 0);
    @(posedge rclk);
    @(posedge rclk);
    #1 rrst_n = 1'b1;
    model_reset();
    cycle(0, 0);

    foreach (vecs[i]) begin
      rinc     = vecs[i].ri;
      m_wr     = vecs[i].w;
      rq2_wptr = gray(vecs[i].w);
      @(posedge rclk);
      #1;
      model_step(vecs[i].ri);
      chk($sformatf("vec%0d_raddr", i), int'(raddr), vecs[i].e_raddr);
      chk($sformatf("vec%0d_rptr", i), int'(rptr), vecs[i].e_rptr);
      chk($sformatf("vec%0d_rempty", i), int'(rempty), int'(vecs[i].e_empty));
      chk($sformatf("vec%0d_raempty", i), int'(raempty), int'(vecs[i].e_aempty));
      chk($sformatf("vec%0d_runderflow", i), int'(runderflow), int'(vecs[i].e_uf));
`ifdef RPTR_LEVEL_EN
      chk($sformatf("vec%0d_rlevel", i), int'(rlevel), vecs[i].e_level);
`endif
    end

    // Advance to rbin=31 keeping one entry ahead, then read across the wrap.
    for (int k = 0; k < 40 && m_rd != 31; k++) cycle(1, m_rd + 2);
    chk("pre_wrap_rd", m_rd, 31);
    cycle(1, 32);
    chk("wrap_raddr", int'(raddr), 0);
    chk("wrap_rptr", int'(rptr), 0);
    chk("wrap_rempty", int'(rempty), 1);

    // Build level 5, then reset asynchronously between edges.
    cycle(0, 5);
    chk("lvl5_raempty", int'(raempty), 0);
    #2 rrst_n = 1'b0;
    #1;
    chk("mid_rst_rempty", int'(rempty), 1);
    chk("mid_rst_raempty", int'(raempty), 1);
    chk("mid_rst_rptr", int'(rptr), 0);
    chk("mid_rst_raddr", int'(raddr), 0);
    chk("mid_rst_runderflow", int'(runderflow), 0);
`ifdef RPTR_LEVEL_EN
    chk("mid_rst_rlevel", int'(rlevel), 0);
`endif
    rinc = 1'b0;
    rq2_wptr = '0;
    @(posedge rclk);
    #1 rrst_n = 1'b1;
    model_reset();
    cycle(0, 0);

    for (int k = 0; k < 600; k++) begin
      int w;
      bit ri;
      w  = m_wr;
      ri = ($urandom_range(0, 99) < 55);
      if (((m_wr - m_rd + MOD) % MOD) < 16 && $urandom_range(0, 99) < 50) w = m_wr + 1;
      cycle(ri, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
